// File: rtl/spi_sram_emulator.sv
// SPI mode-0 serial SRAM slave (23LCxxx command subset), oversampled in the clk domain.
// Supports READ/WRITE/RDMR/WRMR with byte, page and sequential addressing over an on-chip byte array.
module spi_sram_emulator #(
  parameter int MEM_BYTES   = 4096,
  parameter int ADDR_BYTES  = 2,
  parameter int PAGE_BYTES  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_si,
  output logic       spi_so,
  output logic       spi_so_oe,
  output logic [1:0] mode_o,
  output logic       cmd_err
);
  localparam int AW = $clog2(MEM_BYTES);
  localparam int SW = 8 * ADDR_BYTES;
  localparam int CW = $clog2(SW) + 1;
  localparam logic [CW-1:0] CNT_BYTE_LAST = CW'(7);
  localparam logic [CW-1:0] CNT_ADDR_LAST = CW'(SW - 1);
  localparam logic [AW-1:0] PAGE_MASK     = AW'(PAGE_BYTES - 1);
  localparam logic [1:0]    MODE_BYTE     = 2'b00;
  localparam logic [1:0]    MODE_PAGE     = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_RD_DATA, S_WR_DATA, S_WR_MODE, S_DONE
  } state_t;

  function automatic logic [AW-1:0] f_next_addr(input logic [AW-1:0] a, input logic [1:0] m);
    logic [AW-1:0] inc;
    inc = a + AW'(1);
    case (m)
      MODE_BYTE: f_next_addr = a;
      MODE_PAGE: f_next_addr = (a & ~PAGE_MASK) | (inc & PAGE_MASK);
      default:   f_next_addr = inc;
    endcase
  endfunction

  logic [SYNC_STAGES-1:0] r_sck_sync, r_cs_sync, r_si_sync;
  logic                   r_sck_d;
  logic                   w_sck, w_cs_n, w_si, w_sck_rise, w_sck_fall;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [SW-2:0] r_shift, w_shift_nxt;
  logic [SW-1:0] w_shift_in;
  logic [7:0]    w_byte_in, w_rd_byte;
  logic [AW-1:0] r_addr, w_addr_nxt;
  logic [7:0]    r_rd_sh, w_rd_sh_nxt;
  logic [1:0]    r_mode, w_mode_nxt;
  logic          r_so, w_so_nxt, r_oe, w_oe_nxt, r_cmd_err, w_err_nxt;
  logic          r_rdmr, w_rdmr_nxt, r_op_wr, w_op_wr_nxt;
  logic          r_bdone, w_bdone_nxt, r_armed, w_armed_nxt;
  logic          w_mem_we;
  logic [7:0]    r_mem [MEM_BYTES];

  // Synchronise the SPI pins and keep the previous sck level for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_sync <= '0;
      r_cs_sync  <= '0;
      r_si_sync  <= '0;
      r_sck_d    <= 1'b0;
    end else begin
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
      r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      r_si_sync  <= {r_si_sync[SYNC_STAGES-2:0], spi_si};
      r_sck_d    <= w_sck;
    end
  end

  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_cs_n     = r_cs_sync[SYNC_STAGES-1];
  assign w_si       = r_si_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck & ~r_sck_d;
  assign w_sck_fall = ~w_sck & r_sck_d;
  assign w_shift_in = {r_shift, w_si};
  assign w_byte_in  = w_shift_in[7:0];

  // Byte array; deliberately not reset so contents survive rst_n
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_addr] <= w_byte_in;
    end
  end

  // Next-state logic; the 8th-bit write is decided before cs_n so a coincident deselect still commits
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_addr_nxt  = r_addr;
    w_rd_sh_nxt = r_rd_sh;
    w_mode_nxt  = r_mode;
    w_so_nxt    = r_so;
    w_oe_nxt    = r_oe;
    w_err_nxt   = r_cmd_err;
    w_rdmr_nxt  = r_rdmr;
    w_op_wr_nxt = r_op_wr;
    w_bdone_nxt = r_bdone;
    w_armed_nxt = r_armed | w_cs_n;
    w_mem_we    = w_sck_rise && (r_state == S_WR_DATA) && (r_cnt == CNT_BYTE_LAST) && !r_bdone;
    w_rd_byte   = r_bdone ? 8'h00 : (r_rdmr ? {r_mode, 6'b000000} : r_mem[r_addr]);
    if (w_cs_n) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_so_nxt    = 1'b0;
      w_oe_nxt    = 1'b0;
      w_bdone_nxt = 1'b0;
    end else begin
      if (w_sck_rise) begin
        w_shift_nxt = w_shift_in[SW-2:0];
      end else begin
        w_shift_nxt = r_shift;
      end
      case (r_state)
        S_IDLE: begin
          // after rst_n the device waits for a full deselect before decoding bits
          if (r_armed) begin
            w_state_nxt = S_CMD;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_CMD: begin
          if (w_sck_rise && (r_cnt == CNT_BYTE_LAST)) begin
            w_cnt_nxt   = '0;
            w_bdone_nxt = 1'b0;
            w_rdmr_nxt  = 1'b0;
            case (w_byte_in)
              8'h03:   begin w_state_nxt = S_ADDR; w_op_wr_nxt = 1'b0; end
              8'h02:   begin w_state_nxt = S_ADDR; w_op_wr_nxt = 1'b1; end
              8'h05:   begin w_state_nxt = S_RD_DATA; w_rdmr_nxt = 1'b1; end
              8'h01:   w_state_nxt = S_WR_MODE;
              default: begin w_state_nxt = S_DONE; w_err_nxt = 1'b1; end
            endcase
          end else if (w_sck_rise) begin
            w_cnt_nxt = r_cnt + CW'(1);
          end else begin
            w_cnt_nxt = r_cnt;
          end
        end
        S_ADDR: begin
          if (w_sck_rise && (r_cnt == CNT_ADDR_LAST)) begin
            w_cnt_nxt   = '0;
            w_addr_nxt  = AW'(w_shift_in);
            w_state_nxt = r_op_wr ? S_WR_DATA : S_RD_DATA;
          end else if (w_sck_rise) begin
            w_cnt_nxt = r_cnt + CW'(1);
          end else begin
            w_cnt_nxt = r_cnt;
          end
        end
        S_RD_DATA: begin
          if (w_sck_fall && (r_cnt == '0)) begin
            w_oe_nxt    = 1'b1;
            w_so_nxt    = w_rd_byte[7];
            w_rd_sh_nxt = {w_rd_byte[6:0], 1'b0};
            w_cnt_nxt   = CW'(1);
          end else if (w_sck_fall) begin
            w_oe_nxt    = 1'b1;
            w_so_nxt    = r_rd_sh[7];
            w_rd_sh_nxt = {r_rd_sh[6:0], 1'b0};
            if (r_cnt == CNT_BYTE_LAST) begin
              w_cnt_nxt   = '0;
              w_addr_nxt  = r_rdmr ? r_addr : f_next_addr(r_addr, r_mode);
              w_bdone_nxt = r_bdone | (!r_rdmr && (r_mode == MODE_BYTE));
            end else begin
              w_cnt_nxt = r_cnt + CW'(1);
            end
          end else begin
            w_cnt_nxt = r_cnt;
          end
        end
        S_WR_DATA: begin
          if (w_sck_rise && (r_cnt == CNT_BYTE_LAST)) begin
            w_cnt_nxt   = '0;
            w_addr_nxt  = f_next_addr(r_addr, r_mode);
            w_bdone_nxt = r_bdone | (r_mode == MODE_BYTE);
          end else if (w_sck_rise) begin
            w_cnt_nxt = r_cnt + CW'(1);
          end else begin
            w_cnt_nxt = r_cnt;
          end
        end
        S_WR_MODE: begin
          if (w_sck_rise && (r_cnt == CNT_BYTE_LAST)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_DONE;
            if (w_byte_in[7:6] != 2'b11) begin
              w_mode_nxt = w_byte_in[7:6];
            end else begin
              w_mode_nxt = r_mode;
            end
          end else if (w_sck_rise) begin
            w_cnt_nxt = r_cnt + CW'(1);
          end else begin
            w_cnt_nxt = r_cnt;
          end
        end
        S_DONE:  w_state_nxt = S_DONE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_addr    <= '0;
      r_rd_sh   <= 8'h00;
      r_mode    <= 2'b01;
      r_so      <= 1'b0;
      r_oe      <= 1'b0;
      r_cmd_err <= 1'b0;
      r_rdmr    <= 1'b0;
      r_op_wr   <= 1'b0;
      r_bdone   <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_addr    <= w_addr_nxt;
      r_rd_sh   <= w_rd_sh_nxt;
      r_mode    <= w_mode_nxt;
      r_so      <= w_so_nxt;
      r_oe      <= w_oe_nxt;
      r_cmd_err <= w_err_nxt;
      r_rdmr    <= w_rdmr_nxt;
      r_op_wr   <= w_op_wr_nxt;
      r_bdone   <= w_bdone_nxt;
      r_armed   <= w_armed_nxt;
    end
  end

  assign spi_so    = r_so;
  assign spi_so_oe = r_oe;
  assign mode_o    = r_mode;
  assign cmd_err   = r_cmd_err;

endmodule

// File: tb/tb_spi_sram_emulator.sv
// Scoreboard bench for spi_sram_emulator: a bit-banging SPI master pushes expected read bytes,
// a monitor sampling spi_so on sck rise pops and compares them and checks oe against the phase.
module tb_spi_sram_emulator;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_sck = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_si = 1'b0;
  logic       spi_so, spi_so_oe, cmd_err;
  logic [1:0] mode_o;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  logic       exp_oe = 1'b0;
  logic [7:0] mon_byte = 8'h00;
  int         mon_bits = 0;

  spi_sram_emulator #(
    .MEM_BYTES(4096), .ADDR_BYTES(2), .PAGE_BYTES(32), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_si(spi_si),
    .spi_so(spi_so), .spi_so_oe(spi_so_oe), .mode_o(mode_o), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: the master samples spi_so on sck rise, like a real mode-0 host
  always @(posedge spi_sck or posedge spi_cs_n) begin
    if (spi_cs_n) begin
      mon_bits = 0;
    end else begin
      check("oe_phase", {7'd0, spi_so_oe}, {7'd0, exp_oe});
      if (spi_so_oe) begin
        mon_byte = {mon_byte[6:0], spi_so};
        mon_bits++;
        if (mon_bits == 8) begin
          mon_bits = 0;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rd_byte: got 0x%02h but nothing expected", mon_byte);
          end else begin
            check("rd_byte", mon_byte, exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic spi_bits(input logic [7:0] d, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      spi_si = d[i];
      #80 spi_sck = 1'b1;
      #80 spi_sck = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] d);
    spi_bits(d, 8);
  endtask

  task automatic cs_low;
    @(negedge clk);
    spi_cs_n = 1'b0;
    #80;
  endtask

  task automatic cs_high;
    #80;
    exp_oe = 1'b0;
    spi_cs_n = 1'b1;
    #200;
  endtask

  task automatic sram_write(input logic [15:0] a, input int n,
                            input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    cs_low;
    spi_byte(8'h02); spi_byte(a[15:8]); spi_byte(a[7:0]);
    spi_byte(b0);
    if (n > 1) spi_byte(b1);
    if (n > 2) spi_byte(b2);
    cs_high;
  endtask

  task automatic sram_read(input logic [15:0] a, input int n);
    cs_low;
    spi_byte(8'h03); spi_byte(a[15:8]); spi_byte(a[7:0]);
    exp_oe = 1'b1;
    repeat (n) spi_byte(8'h00);
    cs_high;
  endtask

  task automatic wrmr(input logic [7:0] m);
    cs_low;
    spi_byte(8'h01); spi_byte(m);
    cs_high;
  endtask

  task automatic rdmr(input int n);
    cs_low;
    spi_byte(8'h05);
    exp_oe = 1'b1;
    repeat (n) spi_byte(8'h00);
    cs_high;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #23;
    check("rst_so", {7'd0, spi_so}, 8'h00);
    check("rst_oe", {7'd0, spi_so_oe}, 8'h00);
    check("rst_mode", {6'd0, mode_o}, 8'h01);
    check("rst_err", {7'd0, cmd_err}, 8'h00);
    rst_n = 1'b1;
    #100;

    // basic write then sequential read
    sram_write(16'h0010, 2, 8'hA5, 8'h5A, 8'h00);
    exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
    sram_read(16'h0010, 2);

    // sequential wrap at the top of the array, and ignored upper address bits
    sram_write(16'h0FFF, 2, 8'h11, 8'h22, 8'h00);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    sram_read(16'h0FFF, 2);
    exp_q.push_back(8'h11);
    sram_read(16'hFFFF, 1);

    // page mode wrap, RDMR repeat, reserved mode ignored
    wrmr(8'h80);
    check("mode_page", {6'd0, mode_o}, 8'h02);
    sram_write(16'h001F, 3, 8'hB1, 8'hB2, 8'hB3);
    exp_q.push_back(8'h80); exp_q.push_back(8'h80);
    rdmr(2);
    wrmr(8'hC0);
    check("mode_rsvd", {6'd0, mode_o}, 8'h02);
    exp_q.push_back(8'h80);
    rdmr(1);
    wrmr(8'h40);
    check("mode_seq", {6'd0, mode_o}, 8'h01);
    exp_q.push_back(8'hB1);
    sram_read(16'h001F, 1);
    exp_q.push_back(8'hB2); exp_q.push_back(8'hB3);
    sram_read(16'h0000, 2);

    // byte mode: extra write byte dropped, extra read bits are zero
    sram_write(16'h0040, 2, 8'h77, 8'h99, 8'h00);
    wrmr(8'h00);
    check("mode_byte", {6'd0, mode_o}, 8'h00);
    sram_write(16'h0040, 2, 8'h01, 8'h02, 8'h00);
    exp_q.push_back(8'h01); exp_q.push_back(8'h00);
    sram_read(16'h0040, 2);
    wrmr(8'h40);
    exp_q.push_back(8'h99);
    sram_read(16'h0041, 1);

    // aborted write leaves the target untouched
    sram_write(16'h0050, 1, 8'h3C, 8'h00, 8'h00);
    cs_low;
    spi_byte(8'h02); spi_byte(8'h00); spi_byte(8'h50);
    spi_bits(8'hFF, 5);
    cs_high;
    exp_q.push_back(8'h3C);
    sram_read(16'h0050, 1);

    // unknown opcode sets the sticky error and never drives so
    check("err_before", {7'd0, cmd_err}, 8'h00);
    cs_low;
    spi_byte(8'hFF); spi_byte(8'hAA);
    #40;
    check("err_so", {7'd0, spi_so}, 8'h00);
    check("err_oe", {7'd0, spi_so_oe}, 8'h00);
    check("err_set", {7'd0, cmd_err}, 8'h01);
    cs_high;
    check("err_sticky", {7'd0, cmd_err}, 8'h01);
    exp_q.push_back(8'hA5);
    sram_read(16'h0010, 1);

    // rst_n in the middle of a READ data phase
    wrmr(8'h80);
    check("mode_pre_rst", {6'd0, mode_o}, 8'h02);
    cs_low;
    spi_byte(8'h03); spi_byte(8'h00); spi_byte(8'h10);
    exp_oe = 1'b1;
    spi_bits(8'h00, 2);
    #40;
    check("mid_so", {7'd0, spi_so}, 8'h01);
    check("mid_oe", {7'd0, spi_so_oe}, 8'h01);
    rst_n = 1'b0;
    exp_oe = 1'b0;
    #1;
    check("arst_so", {7'd0, spi_so}, 8'h00);
    check("arst_oe", {7'd0, spi_so_oe}, 8'h00);
    check("arst_mode", {6'd0, mode_o}, 8'h01);
    check("arst_err", {7'd0, cmd_err}, 8'h00);
    #50;
    rst_n = 1'b1;
    #100;
    // still selected: a READ sent now must be ignored until cs_n goes high
    spi_byte(8'h03); spi_byte(8'h00); spi_byte(8'h10); spi_byte(8'h00);
    cs_high;
    exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
    sram_read(16'h0010, 2);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: %0d bytes never read, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
